// File: rtl/m_memtest.sv
// Memory test engine: writes a seeded pattern over a region in bursts,
// reads it back over the same request/response streams and counts mismatches.
module m_memtest #(
  parameter logic [7:0]  SRC_ID     = 8'h00,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_BURSTS = 16,
  parameter int          BURST_LEN  = 4,
  parameter logic [4:0]  BEN_FULL   = 5'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        O_TVALID,
  input  logic        O_TREADY,
  output logic [63:0] O_TDATA,
  output logic        O_TLAST,
  input  logic        I_TVALID,
  output logic        I_TREADY,
  input  logic [63:0] I_TDATA,
  input  logic        I_TLAST,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_HDR,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_HDR,
    S_RD_RESP_HDR,
    S_RD_RESP_DATA,
    S_DONE
  } state_e;

  localparam logic [1:0]  T_READ      = 2'b00;
  localparam logic [1:0]  T_WRITE     = 2'b01;
  localparam logic [1:0]  T_RDATA     = 2'b10;
  localparam logic [1:0]  T_WRACK     = 2'b11;
  localparam logic [31:0] BASE_AL     = {BASE_ADDR[31:3], 3'b000};
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] err_q, err_d;
  logic [31:0] ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [31:0] beat_addr;
  logic [31:0] pat_w;
  logic [63:0] pat;
  logic [63:0] hdr;
  logic        o_fire;
  logic        i_fire;
  logic [1:0]  err_inc;
  logic        data_bad;
  logic        last_beat;
  logic [16:0] err_sum;

  // Expected pattern for the beat currently addressed
  always_comb begin
    beat_addr = addr_q + {21'b0, beat_cnt_q, 3'b000};
    pat_w     = {3'b000, beat_addr[31:3]} ^ seed_q;
    pat       = {pat_w, ~pat_w};
  end

  // Request header for the current burst
  always_comb begin
    hdr         = '0;
    hdr[63:59]  = BEN_FULL;
    hdr[55:48]  = SRC_ID;
    hdr[31:3]   = addr_q[31:3];
    if (state_q == S_RD_HDR) begin
      hdr[47:40] = LAST_BEAT;
      hdr[33:32] = T_READ;
    end else begin
      hdr[33:32] = T_WRITE;
    end
  end

  // Stream outputs decoded from the registered state
  always_comb begin
    O_TVALID = (state_q == S_WR_HDR) || (state_q == S_WR_DATA) ||
               (state_q == S_RD_HDR);
    O_TDATA  = '0;
    if (O_TVALID) O_TDATA = (state_q == S_WR_DATA) ? pat : hdr;
    O_TLAST  = (state_q == S_RD_HDR) ||
               ((state_q == S_WR_DATA) && (beat_cnt_q == LAST_BEAT));
    I_TREADY = !O_TVALID;
    o_fire   = O_TVALID && O_TREADY;
    i_fire   = I_TVALID && I_TREADY;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    burst_cnt_d = burst_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    seed_d      = seed_q;
    err_d       = err_q;
    ferr_d      = ferr_q;
    err_inc     = 2'd0;
    data_bad    = 1'b0;
    last_beat   = 1'b0;
    err_sum     = '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WR_HDR;
          addr_d      = BASE_AL;
          burst_cnt_d = '0;
          beat_cnt_d  = '0;
          err_d       = '0;
          ferr_d      = '0;
          seed_d      = seed;
        end
      end
      S_WR_HDR: begin
        if (o_fire) begin
          state_d    = S_WR_DATA;
          beat_cnt_d = '0;
        end
      end
      S_WR_DATA: begin
        if (o_fire) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == LAST_BEAT) state_d = S_WR_ACK;
        end
      end
      S_WR_ACK: begin
        if (i_fire) begin
          if ((I_TDATA[33:32] != T_WRACK) || !I_TLAST) err_inc = 2'd1;
          if (burst_cnt_q == LAST_BURST) begin
            state_d     = S_RD_HDR;
            addr_d      = BASE_AL;
            burst_cnt_d = '0;
          end else begin
            state_d     = S_WR_HDR;
            addr_d      = addr_q + BURST_BYTES;
            burst_cnt_d = burst_cnt_q + 16'd1;
          end
        end
      end
      S_RD_HDR: begin
        if (o_fire) state_d = S_RD_RESP_HDR;
      end
      S_RD_RESP_HDR: begin
        if (i_fire) begin
          if (I_TDATA[33:32] != T_RDATA) err_inc = 2'd1;
          state_d    = S_RD_RESP_DATA;
          beat_cnt_d = '0;
        end
      end
      S_RD_RESP_DATA: begin
        if (i_fire) begin
          data_bad   = (I_TDATA != pat);
          last_beat  = (beat_cnt_q == LAST_BEAT);
          err_inc    = {1'b0, data_bad} + {1'b0, I_TLAST != last_beat};
          if (data_bad && (err_q == 16'd0)) ferr_d = beat_addr;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (I_TLAST || last_beat) begin
            addr_d = addr_q + BURST_BYTES;
            if (burst_cnt_q == LAST_BURST) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_RD_HDR;
              burst_cnt_d = burst_cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_inc != 2'd0) begin
      err_sum = {1'b0, err_q} + {15'b0, err_inc};
      err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  // Status flags follow the state being entered
  always_comb begin
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == 16'd0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
      seed_q      <= '0;
      err_q       <= '0;
      ferr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      burst_cnt_q <= burst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      seed_q      <= seed_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule
